store_data_merge: RTL and testbench
===================================

// Module: store_data_merge
// PURPOSE
//  Store-side counterpart of the load extender: writes byte/halfword/word store data into a
//  32-bit word-wide data memory that has no byte enables.
//  Sub-word stores use read-modify-write (read word, merge lane, write back); aligned word
//  stores write directly.
//  Sits between the LSU store request and the data memory port.
// PARAMETERS
//  ADDR_W   32   byte-address width of req_addr; mem_addr is ADDR_W-2 bits (word address)
// PORTS
//  clk        in   1         single clock, all logic on rising edge
//  rst        in   1         synchronous reset, active-high
//  req_valid  in   1         store request present
//  req_ready  out  1         block can accept a request (high only in IDLE)
//  req_addr   in   ADDR_W    byte address
//  req_data   in   32        store data, right-justified (byte in [7:0], half in [15:0])
//  req_size   in   2         00 byte, 01 half, 10 word, 11 reserved
//  mem_addr   out  ADDR_W-2  word address to memory
//  mem_rd_en  out  1         read strobe; mem_rdata valid exactly 1 cycle later
//  mem_rdata  in   32        memory read data
//  mem_wr_en  out  1         write strobe (one cycle per store)
//  mem_wdata  out  32        full word to write
//  st_done    out  1         1-cycle pulse in the cycle the write is issued
//  st_err     out  1         1-cycle pulse on a misaligned or reserved-size request
// BEHAVIOUR
//  - Reset: state=IDLE. Outputs: req_ready=1. mem_rd_en, mem_wr_en, st_done and st_err are 0.
//    mem_addr, mem_wdata and all internal registers are 0.
//  - Handshake: a request is accepted when req_valid & req_ready at a clock edge.
//    addr, data and size are latched on acceptance.
//    req_ready=0 in every state except IDLE; inputs are ignored while busy.
//  - FSM states IDLE, RD, MRG, WR, ERR:
//    IDLE -> ERR on acceptance if the request is illegal:
//            size=11, or half with addr[0]=1, or word with addr[1:0]!=0.
//    IDLE -> WR  on acceptance of a legal word; wdata = req_data.
//    IDLE -> RD  on acceptance of a legal byte or half.
//    RD : mem_rd_en=1, mem_addr=addr[ADDR_W-1:2]          -> MRG
//    MRG: merge mem_rdata with the store lane into a register -> WR
//         byte: lane addr[1:0]*8 replaced by data[7:0].
//         half: bits [31:16] if addr[1], else [15:0], replaced by data[15:0].
//         All other bits are taken from mem_rdata unchanged.
//    WR : mem_wr_en=1, mem_addr=word addr, mem_wdata=merged/word, st_done=1 -> IDLE
//    ERR: st_err=1; no memory strobe of any kind               -> IDLE
//  - Latency, counting the acceptance edge as T:
//    word: WR in cycle T+1, ready again at T+2.
//    byte/half: RD T+1, MRG T+2, WR T+3, ready at T+4.
//    err: pulse in T+1, ready at T+2.
//  - mem_addr holds the latched word address in RD/MRG/WR and keeps its last value otherwise.
//  - Upper bits of req_data beyond the store size are ignored; they never reach memory.
//  - Back-to-back: a request can be accepted in the IDLE cycle right after WR or ERR.
//  - rst high in any state: next cycle is IDLE with all strobes 0.
//    An in-flight write is dropped; a partial RMW never writes.
//  - mem_rd_en and mem_wr_en are never high in the same cycle.
//    At most one mem_wr_en pulse per accepted request.
// STRUCTURE
//  - lsu_pkg (shared):
//    typedef enum logic [1:0] st_size_e {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD}, used by LSU and decoder;
//    typedef enum st_state_e {IDLE, RD, MRG, WR, ERR};
//    function is_misaligned(addr[1:0], size).
//  - Sub-module byte_lane_merge (purely combinational):
//    inputs old_word, new_data, byte_off[1:0], size; output merged_word.
//    Instantiated once for the MRG datapath.
// TESTING
//  1. Word store: addr=0x100, data=0xDEADBEEF, size=10 -> next cycle wr_en=1, mem_addr=0x40,
//     wdata=0xDEADBEEF, st_done=1, no rd_en.
//  2. Byte store: mem[0x40]=0x11223344; addr=0x102, data=0xFFFFFFAB, size=00 -> rd_en at T+1,
//     wr at T+3 with wdata=0x11AB3344.
//  3. Half store: mem=0x11223344; addr=0x102, data=0x0000BEEF, size=01 -> wdata=0xBEEF3344.
//     Same with addr=0x100 -> wdata=0x1122BEEF.
//  4. Misaligned: half at addr=0x101, word at 0x102, size=11 -> st_err pulse at T+1 each,
//     no rd_en/wr_en, req_ready back at T+2.
//  5. Reset mid-RMW: byte store accepted, rst=1 in the MRG cycle -> mem_wr_en never asserts,
//     req_ready=1 after reset.
//  6. Back-to-back: word then byte with req_valid held high -> second accepted in the IDLE cycle
//     after the first WR; req_ready=0 in all busy cycles.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : lsu_pkg
//  Description : Shared load/store unit types: store size encoding, store
//                merge FSM states and the store alignment check.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

   // Store size as carried on the LSU request bus and decoded by the
   // instruction decoder.
   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } st_size_e;

   // States of the store read-modify-write sequencer.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      MRG  = 3'd2,
      WR   = 3'd3,
      ERR  = 3'd4
   } st_state_e;

   // Width of the data memory word.
   localparam int c_WORD_W = 32;

   // Width of the widest sub-word store lane (halfword).
   localparam int c_LANE_W = 16;

   // True when the low address bits do not match the natural alignment of
   // the access. Bytes are always aligned; the reserved size is rejected
   // separately by the caller.
   function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                          input st_size_e   size);
      logic mis;
      mis = 1'b0;
      case (size)
         SZ_HALF: mis = addr_lo[0];
         SZ_WORD: mis = (addr_lo != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/store_data_merge_byte_lane_merge.sv
`default_nettype none
// ============================================================================
//  Module      : byte_lane_merge
//  Description : Combinational lane merge for sub-word stores. Replaces the
//                addressed byte or halfword of the old memory word with the
//                right-justified store data; all other bits pass through.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_merge
   import lsu_pkg::*;
(
   input  logic [c_WORD_W-1:0] old_word_i,
   input  logic [c_LANE_W-1:0] new_data_i,
   input  logic [1:0]          byte_off_i,
   input  st_size_e            size_i,
   output logic [c_WORD_W-1:0] merged_word_o
);

   // Overlay the store lane on the old word; untouched lanes keep memory data.
   always_comb begin
      merged_word_o = old_word_i;
      case (size_i)
         SZ_BYTE: begin
            case (byte_off_i)
               2'd0:    merged_word_o[7:0]   = new_data_i[7:0];
               2'd1:    merged_word_o[15:8]  = new_data_i[7:0];
               2'd2:    merged_word_o[23:16] = new_data_i[7:0];
               default: merged_word_o[31:24] = new_data_i[7:0];
            endcase
         end
         SZ_HALF: begin
            // Only offsets 0 and 2 reach here; bit 0 was rejected upstream.
            if (byte_off_i[1]) begin
               merged_word_o[31:16] = new_data_i;
            end else begin
               merged_word_o[15:0]  = new_data_i;
            end
         end
         default: merged_word_o = old_word_i;
      endcase
   end

endmodule : byte_lane_merge
`default_nettype wire

// File: rtl/store_data_merge.sv
`default_nettype none
// ============================================================================
//  Module      : store_data_merge
//  Description : Store path into a 32-bit data memory without byte enables.
//                Word stores are written directly; byte and halfword stores
//                are performed as read / merge / write. Illegal requests
//                produce a one-cycle error pulse and never touch memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_data_merge
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [ADDR_W-1:0]    req_addr_i,
   input  logic [c_WORD_W-1:0]  req_data_i,
   input  logic [1:0]           req_size_i,
   output logic [ADDR_W-3:0]    mem_addr_o,
   output logic                 mem_rd_en_o,
   input  logic [c_WORD_W-1:0]  mem_rdata_i,
   output logic                 mem_wr_en_o,
   output logic [c_WORD_W-1:0]  mem_wdata_o,
   output logic                 st_done_o,
   output logic                 st_err_o
);

   st_state_e             state_q;
   logic                  ready_q;
   logic                  rd_en_q;
   logic                  wr_en_q;
   logic                  done_q;
   logic                  err_q;
   logic [ADDR_W-3:0]     mem_addr_q;
   logic [c_WORD_W-1:0]   wdata_q;
   logic [1:0]            byte_off_q;
   st_size_e              size_q;
   logic [c_LANE_W-1:0]   data_q;

   st_size_e              w_req_size;
   logic                  w_accept;
   logic                  w_illegal;
   logic [c_WORD_W-1:0]   merged_d;

   assign w_req_size = st_size_e'(req_size_i);
   assign w_accept   = req_valid_i && ready_q;
   assign w_illegal  = (w_req_size == SZ_RSVD) ||
                       is_misaligned(req_addr_i[1:0], w_req_size);

   // Merge datapath: memory read data arrives during MRG and is folded with
   // the latched store lane.
   byte_lane_merge u_merge (
      .old_word_i    (mem_rdata_i),
      .new_data_i    (data_q),
      .byte_off_i    (byte_off_q),
      .size_i        (size_q),
      .merged_word_o (merged_d)
   );

   // Store sequencer with registered outputs; strobes are one-cycle pulses
   // set on the edge entering the state that owns them.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ready_q    <= 1'b1;
         rd_en_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         mem_addr_q <= '0;
         wdata_q    <= '0;
         byte_off_q <= 2'b00;
         size_q     <= SZ_BYTE;
         data_q     <= '0;
      end else begin
         rd_en_q <= 1'b0;
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (w_accept) begin
                  ready_q    <= 1'b0;
                  byte_off_q <= req_addr_i[1:0];
                  size_q     <= w_req_size;
                  // Only the low lane is kept; upper store bits of a
                  // sub-word request can never reach memory.
                  data_q     <= req_data_i[c_LANE_W-1:0];
                  if (w_illegal) begin
                     // mem_addr deliberately keeps its previous value.
                     err_q   <= 1'b1;
                     state_q <= ERR;
                  end else begin
                     mem_addr_q <= req_addr_i[ADDR_W-1:2];
                     if (w_req_size == SZ_WORD) begin
                        wdata_q <= req_data_i;
                        wr_en_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= WR;
                     end else begin
                        rd_en_q <= 1'b1;
                        state_q <= RD;
                     end
                  end
               end
            end
            RD: begin
               // Read strobe is out this cycle; data is valid in MRG.
               state_q <= MRG;
            end
            MRG: begin
               wdata_q <= merged_d;
               wr_en_q <= 1'b1;
               done_q  <= 1'b1;
               state_q <= WR;
            end
            WR, ERR: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign req_ready_o = ready_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_rd_en_o = rd_en_q;
   assign mem_wr_en_o = wr_en_q;
   assign mem_wdata_o = wdata_q;
   assign st_done_o   = done_q;
   assign st_err_o    = err_q;

endmodule : store_data_merge
`default_nettype wire

// File: tb/tb_store_data_merge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_data_merge
//  Description : Self-checking bench for store_data_merge with a behavioural
//                word memory and a write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_data_merge;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic [1:0]  req_size;
   logic [29:0] mem_addr;
   logic        mem_rd_en;
   logic [31:0] mem_rdata;
   logic        mem_wr_en;
   logic [31:0] mem_wdata;
   logic        st_done;
   logic        st_err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [29:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [31:0] mem    [0:255];
   logic [31:0] shadow [0:255];

   store_data_merge #(.ADDR_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_addr_i  (req_addr),
      .req_data_i  (req_data),
      .req_size_i  (req_size),
      .mem_addr_o  (mem_addr),
      .mem_rd_en_o (mem_rd_en),
      .mem_rdata_i (mem_rdata),
      .mem_wr_en_o (mem_wr_en),
      .mem_wdata_o (mem_wdata),
      .st_done_o   (st_done),
      .st_err_o    (st_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: read data valid one cycle after the read strobe.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= mem[mem_addr[7:0]];
      if (mem_wr_en) mem[mem_addr[7:0]] <= mem_wdata;
   end

   // Scoreboard side: every write is popped against the expected queue.
   always @(negedge clk) begin
      if (mem_rd_en || mem_wr_en) begin
         checks++;
         if (mem_rd_en && mem_wr_en) begin
            failures++;
            $display("FAIL rd_wr_overlap: rd_en=%b wr_en=%b, required not both", mem_rd_en, mem_wr_en);
         end
      end
      if (mem_wr_en) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write: addr=%h data=%h, required no write", mem_addr, mem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (mem_addr !== e.addr || mem_wdata !== e.data) begin
               failures++;
               $display("FAIL write_data: got addr=%h data=%h, required addr=%h data=%h",
                        mem_addr, mem_wdata, e.addr, e.data);
            end
         end
      end
   end

   // Reference merge by masking, independent of lane case selection.
   function automatic logic [31:0] ref_word(input logic [31:0] old, input logic [31:0] data,
                                            input logic [1:0] off, input logic [1:0] size);
      logic [31:0] mask;
      int          sh;
      case (size)
         2'b00:   begin sh = int'(off) * 8;    mask = 32'h0000_00FF << sh; end
         2'b01:   begin sh = off[1] ? 16 : 0;  mask = 32'h0000_FFFF << sh; end
         default: begin sh = 0;                mask = 32'hFFFF_FFFF;       end
      endcase
      return (old & ~mask) | ((data << sh) & mask);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mem(input int idx, input logic [31:0] v);
      mem[idx]    = v;
      shadow[idx] = v;
   endtask

   task automatic push_exp(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
      wr_t         e;
      logic [31:0] nv;
      nv             = ref_word(shadow[addr[9:2]], data, addr[1:0], size);
      shadow[addr[9:2]] = nv;
      e.addr         = addr[31:2];
      e.data         = nv;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
      req_valid = 1'b1;
      req_addr  = addr;
      req_data  = data;
      req_size  = size;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 1'b0;
      step();
      step();
      @(negedge clk);
      checks++; if (req_ready !== 1'b1)  begin failures++; $display("FAIL reset_ready: got %b want 1", req_ready); end
      checks++; if (mem_rd_en !== 1'b0)  begin failures++; $display("FAIL reset_rd_en: got %b want 0", mem_rd_en); end
      checks++; if (mem_wr_en !== 1'b0)  begin failures++; $display("FAIL reset_wr_en: got %b want 0", mem_wr_en); end
      checks++; if (st_done !== 1'b0)    begin failures++; $display("FAIL reset_done: got %b want 0", st_done); end
      checks++; if (st_err !== 1'b0)     begin failures++; $display("FAIL reset_err: got %b want 0", st_err); end
      checks++; if (mem_addr !== 30'h0)  begin failures++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
      checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
      step();
      rst = 1'b0;
   endtask

   task automatic test_word();
      drive(32'h100, 32'hDEADBEEF, 2'b10);
      push_exp(32'h100, 32'hDEADBEEF, 2'b10);
      step();
      req_valid = 1'b0;
      @(negedge clk);
      checks++; if (mem_wr_en !== 1'b1)       begin failures++; $display("FAIL word_wr_en: got %b want 1", mem_wr_en); end
      checks++; if (mem_rd_en !== 1'b0)       begin failures++; $display("FAIL word_rd_en: got %b want 0", mem_rd_en); end
      checks++; if (mem_addr !== 30'h40)      begin failures++; $display("FAIL word_addr: got %h want 40", mem_addr); end
      checks++; if (mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL word_wdata: got %h want deadbeef", mem_wdata); end
      checks++; if (st_done !== 1'b1)         begin failures++; $display("FAIL word_done: got %b want 1", st_done); end
      checks++; if (req_ready !== 1'b0)       begin failures++; $display("FAIL word_busy: got %b want 0", req_ready); end
      step();
      @(negedge clk);
      checks++; if (req_ready !== 1'b1 || mem_wr_en !== 1'b0) begin
         failures++; $display("FAIL word_ready_back: ready=%b wr_en=%b want 1/0", req_ready, mem_wr_en);
      end
      step();
   endtask

   task automatic run_rmw(input string name, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] size, input logic [31:0] want);
      drive(addr, data, size);
      push_exp(addr, data, size);
      step();
      req_valid = 1'b0;
      @(negedge clk);
      checks++; if (mem_rd_en !== 1'b1 || mem_wr_en !== 1'b0 || req_ready !== 1'b0) begin
         failures++; $display("FAIL %s_rd_cycle: rd=%b wr=%b ready=%b want 1/0/0", name, mem_rd_en, mem_wr_en, req_ready);
      end
      checks++; if (mem_addr !== addr[31:2]) begin
         failures++; $display("FAIL %s_rd_addr: got %h want %h", name, mem_addr, addr[31:2]);
      end
      step();
      @(negedge clk);
      checks++; if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0 || req_ready !== 1'b0) begin
         failures++; $display("FAIL %s_mrg_cycle: rd=%b wr=%b ready=%b want 0/0/0", name, mem_rd_en, mem_wr_en, req_ready);
      end
      step();
      @(negedge clk);
      checks++; if (mem_wr_en !== 1'b1 || st_done !== 1'b1) begin
         failures++; $display("FAIL %s_wr_cycle: wr=%b done=%b want 1/1", name, mem_wr_en, st_done);
      end
      checks++; if (mem_wdata !== want) begin
         failures++; $display("FAIL %s_wdata: got %h want %h", name, mem_wdata, want);
      end
      step();
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin
         failures++; $display("FAIL %s_ready_back: got %b want 1", name, req_ready);
      end
      step();
   endtask

   task automatic test_byte();
      set_mem(8'h40, 32'h11223344);
      run_rmw("byte", 32'h102, 32'hFFFFFFAB, 2'b00, 32'h11AB3344);
   endtask

   task automatic test_half();
      set_mem(8'h40, 32'h11223344);
      run_rmw("half_hi", 32'h102, 32'h0000BEEF, 2'b01, 32'hBEEF3344);
      set_mem(8'h40, 32'h11223344);
      run_rmw("half_lo", 32'h100, 32'h0000BEEF, 2'b01, 32'h1122BEEF);
   endtask

   task automatic test_misaligned();
      logic [31:0] addrs [3];
      logic [1:0]  sizes [3];
      addrs[0] = 32'h101; sizes[0] = 2'b01;
      addrs[1] = 32'h102; sizes[1] = 2'b10;
      addrs[2] = 32'h100; sizes[2] = 2'b11;
      for (int i = 0; i < 3; i++) begin
         drive(addrs[i], 32'h12345678, sizes[i]);
         step();
         req_valid = 1'b0;
         @(negedge clk);
         checks++; if (st_err !== 1'b1 || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0 ||
                       st_done !== 1'b0 || req_ready !== 1'b0) begin
            failures++; $display("FAIL err_pulse[%0d]: err=%b rd=%b wr=%b done=%b ready=%b want 1/0/0/0/0",
                                 i, st_err, mem_rd_en, mem_wr_en, st_done, req_ready);
         end
         step();
         @(negedge clk);
         checks++; if (req_ready !== 1'b1 || st_err !== 1'b0) begin
            failures++; $display("FAIL err_recover[%0d]: ready=%b err=%b want 1/0", i, req_ready, st_err);
         end
         step();
      end
   endtask

   task automatic test_reset_mid_rmw();
      int wr_seen;
      set_mem(8'h10, 32'hAABBCCDD);
      drive(32'h41, 32'h00000055, 2'b00);
      step();
      req_valid = 1'b0;
      step();
      rst = 1'b1;
      @(negedge clk);
      step();
      rst = 1'b0;
      wr_seen = 0;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1 || mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin
         failures++; $display("FAIL rst_mid_state: ready=%b rd=%b wr=%b want 1/0/0", req_ready, mem_rd_en, mem_wr_en);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         @(negedge clk);
         if (mem_wr_en === 1'b1) wr_seen++;
      end
      checks++; if (wr_seen != 0) begin
         failures++; $display("FAIL rst_mid_no_write: writes=%0d want 0", wr_seen);
      end
      checks++; if (mem[8'h10] !== 32'hAABBCCDD) begin
         failures++; $display("FAIL rst_mid_mem: got %h want aabbccdd", mem[8'h10]);
      end
      step();
   endtask

   task automatic test_back_to_back();
      set_mem(8'h81, 32'h01020304);
      drive(32'h200, 32'hCAFEF00D, 2'b10);
      push_exp(32'h200, 32'hCAFEF00D, 2'b10);
      step();
      drive(32'h207, 32'hFFFFFF9A, 2'b00);
      push_exp(32'h207, 32'hFFFFFF9A, 2'b00);
      @(negedge clk);
      checks++; if (mem_wr_en !== 1'b1 || req_ready !== 1'b0) begin
         failures++; $display("FAIL b2b_first_wr: wr=%b ready=%b want 1/0", mem_wr_en, req_ready);
      end
      step();
      @(negedge clk);
      checks++; if (req_ready !== 1'b1 || mem_rd_en !== 1'b0) begin
         failures++; $display("FAIL b2b_idle_gap: ready=%b rd=%b want 1/0", req_ready, mem_rd_en);
      end
      step();
      req_valid = 1'b0;
      @(negedge clk);
      checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 30'h81 || req_ready !== 1'b0) begin
         failures++; $display("FAIL b2b_second_rd: rd=%b addr=%h ready=%b want 1/81/0", mem_rd_en, mem_addr, req_ready);
      end
      step();
      @(negedge clk);
      checks++; if (req_ready !== 1'b0) begin
         failures++; $display("FAIL b2b_mrg_busy: ready=%b want 0", req_ready);
      end
      step();
      @(negedge clk);
      checks++; if (mem_wr_en !== 1'b1 || mem_wdata !== 32'h9A020304 || req_ready !== 1'b0) begin
         failures++; $display("FAIL b2b_second_wr: wr=%b data=%h ready=%b want 1/9a020304/0", mem_wr_en, mem_wdata, req_ready);
      end
      step();
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin
         failures++; $display("FAIL b2b_ready_back: ready=%b want 1", req_ready);
      end
      step();
   endtask

   task automatic test_random();
      for (int k = 0; k < 12; k++) begin
         logic [1:0]  sz;
         logic [31:0] a;
         logic [31:0] d;
         int          n;
         int          want_n;
         sz = 2'($urandom_range(0, 2));
         a  = {22'd0, 4'($urandom_range(0, 15)), 4'd0, 2'd0};
         a[5:2] = 4'($urandom_range(0, 15));
         if (sz == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
         if (sz == 2'b01) a[1]   = 1'($urandom_range(0, 1));
         d = $urandom;
         push_exp(a, d, sz);
         drive(a, d, sz);
         step();
         req_valid = 1'b0;
         want_n = (sz == 2'b10) ? 1 : 3;
         n = 0;
         @(negedge clk);
         while (req_ready !== 1'b1 && n < 10) begin
            n++;
            step();
            @(negedge clk);
         end
         checks++; if (n != want_n) begin
            failures++; $display("FAIL rand_latency[%0d]: busy cycles=%0d want %0d", k, n, want_n);
         end
         step();
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]    = 32'h0;
         shadow[i] = 32'h0;
      end
      mem_rdata = 32'h0;
      req_valid = 1'b0;
      req_addr  = 32'h0;
      req_data  = 32'h0;
      req_size  = 2'b00;
      rst       = 1'b1;

      test_reset();
      test_word();
      test_byte();
      test_half();
      test_misaligned();
      test_reset_mid_rmw();
      test_back_to_back();
      test_random();

      repeat (3) step();
      checks++; if (exp_q.size() != 0) begin
         failures++; $display("FAIL missing_writes: pending=%0d want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule : tb_store_data_merge
`default_nettype wire
